// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR post-parameter controller: FSM state
// encoding, the default safe-point wait limit and requester indices.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_WAIT_SAFE = 3'd2,
    ST_APPLY     = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd4096;

  // Requester indices into the two-bit request vector.
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_AUTO = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On simultaneous requests the requester
// that was not granted last wins; last-grant resets to AUTO so HOST wins
// first after reset.
module rr_arb2
  import fir_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       vld_o,
  output logic       gnt_o
);

  logic last_q;

  // Winner selection from the current requests and the last grant.
  always_comb begin
    vld_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_o = ~last_q;
    end else if (req_i[REQ_AUTO]) begin
      gnt_o = REQ_AUTO;
    end else begin
      gnt_o = REQ_HOST;
    end
  end

  // Remember who won whenever a grant is actually taken.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q <= REQ_AUTO;
    end else if (update_i && vld_o) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/fir_post_para_ctrl.sv
// FIR post-processing parameter controller. Arbitrates host / motion
// controller parameter updates and applies them only at a safe point of the
// laser scan (track zero crossing between FIR samples, or scan stopped).
// Optional feature macro: FIR_PARA_TIMEOUT_EN bounds the safe-point wait to
// TIMEOUT_CYC cycles and raises a sticky timeout_o when it expires.
module fir_post_para_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter real         TCQ         = 0.1,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        laser_start_i,
  input  logic        fir_laser_vld_i,
  input  logic        fir_laser_zero_flag_i,
  input  logic        host_req_i,
  input  logic [15:0] host_circle_num_i,
  input  logic [15:0] host_track_num_i,
  input  logic        auto_req_i,
  input  logic [15:0] auto_circle_num_i,
  input  logic [15:0] auto_track_num_i,
  output logic        host_ack_o,
  output logic        auto_ack_o,
  output logic [15:0] circle_lose_num_o,
  output logic [15:0] track_align_num_o,
  output logic        fir_post_para_en_o,
  output logic        busy_o,
  output logic        timeout_o
);

  // Elaboration-time sanity check of the configuration.
  if (TCQ < 0.0 || TIMEOUT_CYC < 16'd2) begin : g_param_chk
    $error("fir_post_para_ctrl: TCQ must be >= 0 and TIMEOUT_CYC >= 2");
  end

  state_t      state_q;
  logic        gnt_who_q;
  logic [15:0] shadow_circle_q;
  logic [15:0] shadow_track_q;
  logic [15:0] circle_q;
  logic [15:0] track_q;
  logic        para_en_q;
  logic        host_ack_q;
  logic        auto_ack_q;
  logic        busy_q;
  logic        arb_vld;
  logic        arb_gnt;
  logic        safe_pt;
  logic        tmo_hit;
  logic        go_apply;

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    ({auto_req_i, host_req_i}),
    .update_i (state_q == ST_IDLE),
    .vld_o    (arb_vld),
    .gnt_o    (arb_gnt)
  );

`ifdef FIR_PARA_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        timeout_q;

  // Safe-point wait counter: cleared in GRANT, counts WAIT_SAFE cycles.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_GRANT) begin
      wait_cnt_q <= 16'd0;
    end else if (state_q == ST_WAIT_SAFE) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      timeout_q <= 1'b0;
    end else if (state_q == ST_WAIT_SAFE && tmo_hit && !safe_pt) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Decide whether the pending parameters may be applied this cycle.
  always_comb begin
    safe_pt  = !laser_start_i || (fir_laser_zero_flag_i && !fir_laser_vld_i);
    tmo_hit  = 1'b0;
`ifdef FIR_PARA_TIMEOUT_EN
    tmo_hit  = (wait_cnt_q == TIMEOUT_CYC - 16'd1);
`endif
    go_apply = 1'b0;
    case (state_q)
      ST_GRANT:     go_apply = !laser_start_i;
      ST_WAIT_SAFE: go_apply = safe_pt || tmo_hit;
      default:      go_apply = 1'b0;
    endcase
  end

  // Shadow registers capture the winner's values once, on the grant.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && arb_vld) begin
      shadow_circle_q <= (arb_gnt == REQ_AUTO) ? auto_circle_num_i : host_circle_num_i;
      shadow_track_q  <= (arb_gnt == REQ_AUTO) ? auto_track_num_i  : host_track_num_i;
    end
  end

  // Transaction FSM; every output is registered from the next-state decision.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_who_q  <= REQ_HOST;
      circle_q   <= 16'd0;
      track_q    <= 16'd0;
      para_en_q  <= 1'b0;
      host_ack_q <= 1'b0;
      auto_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      para_en_q  <= 1'b0;
      host_ack_q <= 1'b0;
      auto_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            state_q   <= ST_GRANT;
            gnt_who_q <= arb_gnt;
            busy_q    <= 1'b1;
          end
        end
        ST_GRANT, ST_WAIT_SAFE: begin
          if (go_apply) begin
            state_q   <= ST_APPLY;
            para_en_q <= 1'b1;
            circle_q  <= shadow_circle_q;
            track_q   <= shadow_track_q;
          end else begin
            state_q   <= ST_WAIT_SAFE;
          end
        end
        ST_APPLY: begin
          state_q <= ST_ACK;
          if (gnt_who_q == REQ_AUTO) begin
            auto_ack_q <= 1'b1;
          end else begin
            host_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host_ack_o         = host_ack_q;
  assign auto_ack_o         = auto_ack_q;
  assign circle_lose_num_o  = circle_q;
  assign track_align_num_o  = track_q;
  assign fir_post_para_en_o = para_en_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_fir_post_para_ctrl.sv
// Scoreboard bench for fir_post_para_ctrl. The driver predicts, from the
// behavioural rules (latency, safe points, round-robin order), when each
// apply and ack must appear; a monitor checks every DUT event against them.
module tb_fir_post_para_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        laser_start_i;
  logic        fir_laser_vld_i;
  logic        fir_laser_zero_flag_i;
  logic        host_req_i;
  logic [15:0] host_circle_num_i;
  logic [15:0] host_track_num_i;
  logic        auto_req_i;
  logic [15:0] auto_circle_num_i;
  logic [15:0] auto_track_num_i;
  logic        host_ack_o;
  logic        auto_ack_o;
  logic [15:0] circle_lose_num_o;
  logic [15:0] track_align_num_o;
  logic        fir_post_para_en_o;
  logic        busy_o;
  logic        timeout_o;

  fir_post_para_ctrl #(.TIMEOUT_CYC(16'd16)) dut (
    .clk_i                 (clk_i),
    .rst_n_i               (rst_n_i),
    .laser_start_i         (laser_start_i),
    .fir_laser_vld_i       (fir_laser_vld_i),
    .fir_laser_zero_flag_i (fir_laser_zero_flag_i),
    .host_req_i            (host_req_i),
    .host_circle_num_i     (host_circle_num_i),
    .host_track_num_i      (host_track_num_i),
    .auto_req_i            (auto_req_i),
    .auto_circle_num_i     (auto_circle_num_i),
    .auto_track_num_i      (auto_track_num_i),
    .host_ack_o            (host_ack_o),
    .auto_ack_o            (auto_ack_o),
    .circle_lose_num_o     (circle_lose_num_o),
    .track_align_num_o     (track_align_num_o),
    .fir_post_para_en_o    (fir_post_para_en_o),
    .busy_o                (busy_o),
    .timeout_o             (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  bit rst_at_edge = 1'b0;
  always @(posedge clk_i) begin
    cyc++;
    rst_at_edge = !rst_n_i;
  end

  typedef struct { bit who; logic [15:0] c; logic [15:0] t; int cyc; } apply_t;
  typedef struct { bit who; int cyc; } ack_t;
  apply_t apply_q[$];
  ack_t   ack_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit last_who = 1'b1;  // model of round-robin memory: 0 host, 1 auto

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every apply/ack the DUT presents is matched against the model.
  logic [15:0] prev_c, prev_t;
  apply_t      e;
  ack_t        a;
  always @(negedge clk_i) begin
    if (fir_post_para_en_o === 1'b1) begin
      if (apply_q.size() == 0) begin
        chk("unexpected_apply", 1, 0);
      end else begin
        e = apply_q.pop_front();
        chk("apply_cycle", cyc, e.cyc);
        chk("circle_num", circle_lose_num_o, e.c);
        chk("track_num", track_align_num_o, e.t);
      end
    end else if (!rst_at_edge && (circle_lose_num_o !== prev_c || track_align_num_o !== prev_t)) begin
      chk("num_hold", {circle_lose_num_o, track_align_num_o}, {prev_c, prev_t});
    end
    prev_c = circle_lose_num_o;
    prev_t = track_align_num_o;
    if (host_ack_o === 1'b1 || auto_ack_o === 1'b1) begin
      chk("ack_overlap", host_ack_o & auto_ack_o, 0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        a = ack_q.pop_front();
        chk("ack_cycle", cyc, a.cyc);
        chk("ack_who", auto_ack_o, a.who);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_txn(input bit who, input logic [15:0] c, input logic [15:0] t,
                            input int apply_cyc);
    apply_t ap;
    ack_t   ak;
    ap.who = who; ap.c = c; ap.t = t; ap.cyc = apply_cyc;
    ak.who = who; ak.cyc = apply_cyc + 1;
    apply_q.push_back(ap);
    ack_q.push_back(ak);
    last_who = who;
  endtask

  task automatic wait_ack(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (host_ack_o === 1'b1 || auto_ack_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("ack_wait_budget", 0, 1);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    host_req_i = 1'b0; auto_req_i = 1'b0;
    laser_start_i = 1'b0; fir_laser_vld_i = 1'b0; fir_laser_zero_flag_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    apply_q.delete();
    ack_q.delete();
    last_who = 1'b1;
  endtask

  task automatic drive_req(input bit who, input logic [15:0] c, input logic [15:0] t);
    if (who) begin
      auto_req_i = 1'b1; auto_circle_num_i = c; auto_track_num_i = t;
    end else begin
      host_req_i = 1'b1; host_circle_num_i = c; host_track_num_i = t;
    end
  endtask

  // One isolated transaction. variant: 0 clean safe point, 1 zero flag first
  // seen together with vld, 2 scan stops instead of a zero crossing.
  task automatic run_txn(input bit who, input logic [15:0] c, input logic [15:0] t,
                         input bit laser, input int d, input int variant, input bit early_drop);
    int n, s;
    tick();
    n = cyc;
    laser_start_i = laser;
    drive_req(who, c, t);
    s = n + 2 + d;
    expect_txn(who, c, t, laser ? s + 1 : n + 2);
    tick();
    host_circle_num_i = 16'($urandom); host_track_num_i = 16'($urandom);
    auto_circle_num_i = 16'($urandom); auto_track_num_i = 16'($urandom);
    if (early_drop) begin
      host_req_i = 1'b0; auto_req_i = 1'b0;
    end
    if (laser) begin
      while (cyc < s) begin
        fir_laser_zero_flag_i = (variant == 1 && cyc == s - 1);
        fir_laser_vld_i = fir_laser_zero_flag_i ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
      end
      if (variant == 2) begin
        laser_start_i = 1'b0;
      end else begin
        fir_laser_zero_flag_i = 1'b1; fir_laser_vld_i = 1'b0;
      end
      tick();
      fir_laser_zero_flag_i = 1'b0; fir_laser_vld_i = 1'b0;
    end
    wait_ack(64);
    tick();
    host_req_i = 1'b0; auto_req_i = 1'b0; laser_start_i = 1'b0;
    @(negedge clk_i);
    chk("busy_after_txn", busy_o, 0);
  endtask

  initial begin
    int n, m, acks;
    host_circle_num_i = '0; host_track_num_i = '0;
    auto_circle_num_i = '0; auto_track_num_i = '0;
    do_reset();

    // Reset state
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_para_en", fir_post_para_en_o, 0);
    chk("rst_host_ack", host_ack_o, 0);
    chk("rst_auto_ack", auto_ack_o, 0);
    chk("rst_circle", circle_lose_num_o, 0);
    chk("rst_track", track_align_num_o, 0);
    chk("rst_timeout", timeout_o, 0);

    // Basic host request with scan stopped: latency and busy window
    tick();
    n = cyc;
    drive_req(1'b0, 16'd5, 16'd3);
    expect_txn(1'b0, 16'd5, 16'd3, n + 2);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk_i);
      chk("busy_window", busy_o, (k >= 1 && k <= 3) ? 1 : 0);
    end
    host_req_i = 1'b0;
    tick();

    // Both requesters held from reset: host, auto, host
    do_reset();
    tick();
    n = cyc;
    host_req_i = 1'b1; host_circle_num_i = 16'd11; host_track_num_i = 16'd12;
    auto_req_i = 1'b1; auto_circle_num_i = 16'd21; auto_track_num_i = 16'd22;
    for (int i = 0; i < 3; i++) begin
      bit w;
      w = !last_who;
      expect_txn(w, w ? 16'd21 : 16'd11, w ? 16'd22 : 16'd12, n + 2 + 4 * i);
    end
    acks = 0;
    for (int i = 0; i < 60 && acks < 3; i++) begin
      @(negedge clk_i);
      if (host_ack_o === 1'b1 || auto_ack_o === 1'b1) acks++;
    end
    chk("rr_ack_count", acks, 3);
    host_req_i = 1'b0; auto_req_i = 1'b0;
    tick();
    tick();

    // Auto request during scan, zero crossing 20 cycles after the request
    run_txn(1'b1, 16'd700, 16'd9, 1'b1, 18, 0, 1'b0);
    // Zero flag coincident with vld must not count as a safe point
    run_txn(1'b0, 16'd42, 16'd43, 1'b1, 6, 1, 1'b0);
    // Scan stop as the safe point
    run_txn(1'b1, 16'd77, 16'd88, 1'b1, 4, 2, 1'b1);

    // Randomized isolated transactions
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(1, 12)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

`ifdef FIR_PARA_TIMEOUT_EN
    // No safe point: bounded wait ends after 16 WAIT_SAFE cycles
    tick();
    n = cyc;
    laser_start_i = 1'b1;
    drive_req(1'b1, 16'd1234, 16'd4321);
    expect_txn(1'b1, 16'd1234, 16'd4321, n + 18);
    wait_ack(64);
    tick();
    auto_req_i = 1'b0; laser_start_i = 1'b0;
    @(negedge clk_i);
    chk("timeout_set", timeout_o, 1);
`else
    // No safe point: still waiting after 1000 cycles, then scan stop applies
    tick();
    laser_start_i = 1'b1;
    drive_req(1'b1, 16'd1234, 16'd4321);
    repeat (1000) tick();
    @(negedge clk_i);
    chk("still_waiting_busy", busy_o, 1);
    chk("no_timeout", timeout_o, 0);
    tick();
    m = cyc;
    laser_start_i = 1'b0;
    expect_txn(1'b1, 16'd1234, 16'd4321, m + 1);
    wait_ack(64);
    tick();
    auto_req_i = 1'b0;
`endif

    // Reset while waiting for a safe point abandons the transaction
    tick();
    laser_start_i = 1'b1;
    drive_req(1'b0, 16'd900, 16'd901);
    repeat (5) tick();
    rst_n_i = 1'b0; host_req_i = 1'b0; laser_start_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    last_who = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("post_rst_busy", busy_o, 0);
    end
    chk("post_rst_circle", circle_lose_num_o, 0);
    chk("post_rst_track", track_align_num_o, 0);
    chk("post_rst_timeout", timeout_o, 0);
    run_txn(1'b0, 16'd17, 16'd18, 1'b0, 1, 0, 1'b0);

    repeat (4) tick();
    chk("apply_queue_drained", apply_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
